mem_arb2: RTL
=============

# mem_arb2

Two-client arbiter and sequencer for the 8x16 dual-port memory (`wr_addr`/`rd_addr`/`din`/`dout` style RAM, both ports driven from one clock). Each client issues single-word read or write requests. The block arbitrates the write port and the read port independently, so one write and one read can be granted in the same cycle. It blocks same-address read/write collisions and returns read data to the requesting client with a fixed latency. It sits between the client logic and the memory instance, which it drives directly.

## Interface
Parameters:
- AW, 3, address width (memory depth 2**AW = 8)
- DW, 16, data width

Ports:
- clk  input  1  single clock for the block and the memory
- rst  input  1  synchronous, active-high reset
- req0 / req1  input  1  client request, held until granted
- wr0 / wr1  input  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  input  AW  request address; stable while req high
- wdata0 / wdata1  input  DW  write data; stable while req high
- gnt0 / gnt1  output  1  combinational accept; request consumed at this clock edge
- rvalid0 / rvalid1  output  1  one-cycle pulse, read data valid
- rdata0 / rdata1  output  DW  read data, registered; holds its value between pulses
- mem_we  output  1  memory write enable
- mem_wr_addr  output  AW  memory write address
- mem_din  output  DW  memory write data
- mem_re  output  1  memory read enable
- mem_rd_addr  output  AW  memory read address
- mem_dout  input  DW  memory read data, valid the cycle after mem_re

## Operation
- Write candidates: clients with req & wr. Read candidates: clients with req & ~wr.
- Write arbiter grants one write candidate per cycle. mem_we, mem_wr_addr and mem_din come from the winner, combinationally.
- Read arbiter grants one read candidate per cycle. mem_re and mem_rd_addr come from the winner, combinationally.
- A client has a single request, so it can receive at most one grant per cycle. Different clients can be granted on the two ports in the same cycle.
- Collision rule: if the read winner's addr equals the granted write's addr in the same cycle, the read is not granted. The read pointer does not advance, and the read retries next cycle.
- Round-robin policy: each port has a 1-bit pointer naming the preferred client.
  - When both clients are candidates, the preferred client wins.
  - On a grant, the pointer moves to the other client.
  - With one candidate, that client wins and the pointer moves away from it.
- Read tag pipeline:
  - Stage 1 registers {valid, client} at the edge where mem_re is sampled.
  - Stage 2 captures mem_dout into the tagged client's rdata and pulses that client's rvalid.
- Unused memory-side outputs drive 0 when their enable is low.

## Timing
- Write: gnt and mem_we are asserted in cycle t. The memory is updated at the clock edge ending cycle t.
- Read latency is 2:
  - gnt and mem_re are asserted in cycle t.
  - mem_dout is valid in t+1.
  - rdata and rvalid are visible in t+2.
- Back-to-back reads from the same client are allowed every cycle, and responses return in order.
- Read of an address written in an earlier cycle returns the new data. Same-cycle same-address hazards cannot occur because of the collision rule.
- Reset (rst high at the edge):
  - gnt0/1, mem_we and mem_re are forced 0 combinationally while rst is high.
  - rvalid0/1 and both tag stages clear to 0, and rdata0/1 clear to 0.
  - Both pointers reset to client 0.
- Reset mid-operation: in-flight reads are dropped, with no rvalid afterwards. Requests still held by clients after reset are re-arbitrated normally.

## Configuration
- MEM_ARB_FIXED_PRIO_EN:
  - Defined: client 0 always wins on both ports, and the pointers are not implemented. Client 1 is granted only when client 0 has no candidate request on that port or is blocked by the collision rule.
  - Undefined (default): round-robin behaviour as described above.

## Structure
- Package mem_arb_pkg holds AW and DW default constants, DEPTH = 8, the client index constants CL0 = 0 and CL1 = 1, and the read-tag struct/typedef {valid, client}.
- Sub-module rr_arb2: a two-way arbiter with its pointer register, honouring MEM_ARB_FIXED_PRIO_EN. It is instantiated twice, once for the write port and once for the read port.
- The collision check, tag pipeline and memory-side muxing live in the top module.

## Test plan
- Reset: hold rst for 2 cycles with req0 = req1 = 1 → gnt0/1, mem_we, mem_re, rvalid0/1 all 0 and rdata0/1 = 0; after release, client 0 is granted first.
- Write then read: client 0 writes 16'h00A5 to address 3; client 1 later reads address 3 → rvalid1 pulses exactly 2 cycles after gnt1, with rdata1 = 16'h00A5 and rvalid0 = 0.
- Round robin: both clients hold continuous write requests to addresses 0–7 → grants alternate 0,1,0,1 and no client waits more than 1 cycle. With MEM_ARB_FIXED_PRIO_EN defined, only client 0 is granted until its requests stop.
- Concurrent ports: client 0 writes address 5 while client 1 reads address 2 in the same cycle → both granted, mem_we = mem_re = 1.
- Collision: client 0 writes 16'h1234 to address 6 while client 1 reads address 6 → read stalls 1 cycle, then is granted; rdata1 = 16'h1234.
- Reset mid-read: assert rst the cycle after a read grant → no rvalid occurs for that read, and rdata stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and the read-tag type for the two-client memory arbiter.
package mem_arb_pkg;

    localparam int MEM_AW = 3;
    localparam int MEM_DW = 16;
    localparam int DEPTH  = 8;

    localparam int CL0 = 0;
    localparam int CL1 = 1;

    typedef struct packed {
        logic valid;
        logic client;
    } rd_tag_t;

endpackage

// File: rtl/mem_arb2_rr.sv
// Two-way arbiter used by mem_arb2; round-robin pointer unless MEM_ARB_FIXED_PRIO_EN
// is defined, in which case client 0 always has priority and no pointer exists.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cand,
    input  logic       advance,
    output logic [1:0] win
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr_inputs;
    assign unused_ptr_inputs = clk ^ rst ^ advance;

    always_comb begin
        win = 2'b00;
        if (cand[CL0]) begin
            win[CL0] = 1'b1;
        end else if (cand[CL1]) begin
            win[CL1] = 1'b1;
        end
    end
`else
    logic ptr;

    always_comb begin
        win = cand;
        if (cand == 2'b11) begin
            win      = 2'b00;
            win[ptr] = 1'b1;
        end
    end

    // After any accepted grant the other client becomes preferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'(CL0);
        end else if (advance) begin
            ptr <= ~win[CL1];
        end
    end
`endif

endmodule

// File: rtl/mem_arb2.sv
// Two-client write/read port arbiter and read-data sequencer for an 8x16 dual-port RAM.
// Optional MEM_ARB_FIXED_PRIO_EN makes client 0 the fixed winner on both ports.
module mem_arb2
    import mem_arb_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_we,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_re,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_dout
);

    logic [1:0]    wr_cand;
    logic [1:0]    rd_cand;
    logic [1:0]    wr_win;
    logic [1:0]    rd_win;
    logic          wr_go;
    logic          rd_go;
    logic          collide;
    logic [AW-1:0] wr_sel_addr;
    logic [AW-1:0] rd_sel_addr;
    logic [DW-1:0] wr_sel_data;
    rd_tag_t       tag1;

    assign wr_cand = {req1 & wr1, req0 & wr0};
    assign rd_cand = {req1 & ~wr1, req0 & ~wr0};

    rr_arb2 u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .cand    (wr_cand),
        .advance (wr_go),
        .win     (wr_win)
    );

    rr_arb2 u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .cand    (rd_cand),
        .advance (rd_go),
        .win     (rd_win)
    );

    assign wr_sel_addr = wr_win[CL1] ? addr1  : addr0;
    assign wr_sel_data = wr_win[CL1] ? wdata1 : wdata0;
    assign rd_sel_addr = rd_win[CL1] ? addr1  : addr0;

    // A read aimed at the address being written this cycle waits and retries.
    assign wr_go   = ~rst & (|wr_win);
    assign collide = wr_go & (|rd_win) & (rd_sel_addr == wr_sel_addr);
    assign rd_go   = ~rst & (|rd_win) & ~collide;

    assign gnt0 = (wr_go & wr_win[CL0]) | (rd_go & rd_win[CL0]);
    assign gnt1 = (wr_go & wr_win[CL1]) | (rd_go & rd_win[CL1]);

    assign mem_we      = wr_go;
    assign mem_wr_addr = wr_go ? wr_sel_addr : '0;
    assign mem_din     = wr_go ? wr_sel_data : '0;
    assign mem_re      = rd_go;
    assign mem_rd_addr = rd_go ? rd_sel_addr : '0;

    // Tag follows the read through the RAM latency, then steers mem_dout to its client.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1    <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            tag1.valid  <= rd_go;
            tag1.client <= rd_win[CL1];
            rvalid0     <= tag1.valid & (tag1.client == 1'(CL0));
            rvalid1     <= tag1.valid & (tag1.client == 1'(CL1));
            if (tag1.valid && tag1.client == 1'(CL0)) begin
                rdata0 <= mem_dout;
            end
            if (tag1.valid && tag1.client == 1'(CL1)) begin
                rdata1 <= mem_dout;
            end
        end
    end

endmodule
